// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the single-line SDRAM controller between the fetch port (0) and the load/store port (1).
// Define SDRAM_ARB_RR_EN for round-robin arbitration; by default port 1 has fixed priority over port 0.
module sdram_port_arbiter #(
  parameter int ADDR_W = 24,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_valid,
  input  logic              p0_wr,
  input  logic              p0_rd,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [LINE_W-1:0] p0_wdata,
  output logic [LINE_W-1:0] p0_rdata,
  output logic              p0_done,
  input  logic              p1_valid,
  input  logic              p1_wr,
  input  logic              p1_rd,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [LINE_W-1:0] p1_wdata,
  output logic [LINE_W-1:0] p1_rdata,
  output logic              p1_done,
  output logic              mem_valid,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_done,
  input  logic              mem_init_done,
  output logic              grant
);
  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;
  state_t state_q, state_d;
  logic grant_q, grant_d, mem_valid_q, mem_valid_d, mem_wr_q, mem_wr_d, mem_rd_q, mem_rd_d;
  logic p0_done_q, p0_done_d, p1_done_q, p1_done_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d, p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic req0, req1, start, win, fin;
  assign req0  = p0_valid && (p0_wr || p0_rd);
  assign req1  = p1_valid && (p1_wr || p1_rd);
  assign start = (state_q == IDLE) && mem_init_done && (req0 || req1);
  assign fin   = (state_q == ISSUE) && mem_valid_q && mem_done;
`ifdef SDRAM_ARB_RR_EN
  logic last_q, last_d;
  assign win    = (req0 && req1) ? !last_q : req1;
  assign last_d = start ? win : last_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
`else
  assign win = req1;
`endif
  always_comb begin
    state_d     = state_q;
    grant_d     = start ? win : grant_q;
    mem_valid_d = start ? 1'b1 : (fin ? 1'b0 : mem_valid_q);
    mem_wr_d    = start ? (win ? p1_wr : p0_wr) : (fin ? 1'b0 : mem_wr_q);
    // A command with both wr and rd set is issued as a write.
    mem_rd_d    = start ? (win ? p1_rd && !p1_wr : p0_rd && !p0_wr) : (fin ? 1'b0 : mem_rd_q);
    mem_addr_d  = start ? (win ? p1_addr : p0_addr) : mem_addr_q;
    mem_wdata_d = start ? (win ? p1_wdata : p0_wdata) : mem_wdata_q;
    p0_done_d   = fin && !grant_q;
    p1_done_d   = fin && grant_q;
    p0_rdata_d  = (fin && mem_rd_q && !grant_q) ? mem_rdata : p0_rdata_q;
    p1_rdata_d  = (fin && mem_rd_q && grant_q) ? mem_rdata : p1_rdata_q;
    case (state_q)
      IDLE:    state_d = start ? ISSUE : IDLE;
      ISSUE:   state_d = fin ? RELEASE : ISSUE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      p0_done_q   <= 1'b0;
      p1_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_valid_q <= mem_valid_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_done_q   <= p0_done_d;
      p1_done_q   <= p1_done_d;
    end
  end
  assign grant     = grant_q;
  assign mem_valid = mem_valid_q;
  assign mem_wr    = mem_wr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign p0_done   = p0_done_q;
  assign p1_done   = p1_done_q;
endmodule
